pattern_sched: RTL and testbench
================================

# pattern_sched

Time-multiplexed scheduler that shares one serial pattern-match engine among NCH independent bit-stream channels. Each cycle, a round-robin arbiter picks one requesting channel. The block loads that channel's saved detector context, advances it by the channel's bit, and writes it back. It then reports which channel matched. It sits between the per-lane bit sources and the frame/alarm logic, replacing one detector FSM per lane with a single shared engine plus a context bank.

## Interface
- NCH, 4: number of channels (2..16)
- PLEN, 5: pattern length in bits (2..16)
- PATTERN, 5'b01101: target pattern, MSB = first bit received
- clk_i  input  1  single clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- req_i  input  NCH  per-channel request; bit k valid on d_i[k]
- d_i  input  NCH  per-channel serial data bit
- flush_i  input  NCH  per-channel context clear
- ack_o  output  NCH  one-hot grant; bit consumed at this edge
- det_valid_o  output  1  result strobe
- det_ch_o  output  $clog2(NCH)  channel of the result
- det_o  output  1  pattern completed on det_ch_o

## Operation
- Per-channel context: shift register sh[PLEN-1:0] and fill count fc (0..PLEN, saturating). Reset and flush values: sh=0, fc=0.
- Handshake: requester holds req_i[k] and d_i[k] stable until it samples ack_o[k]=1. The bit is consumed on that rising edge. At most one ack_o bit is set per cycle.
- ack_o is combinational from req_i, flush_i and the priority pointer. It is 0 while rst_ni=0.
- Arbitration is round-robin. Pointer ptr (reset 0) marks the highest-priority channel. After a grant to channel g, ptr = (g+1) mod NCH. With no grant, ptr holds.
- Engine update for granted channel g:
  - sh' = {sh[PLEN-2:0], d_i[g]}
  - fc' = min(fc+1, PLEN)
  - hit = (fc' == PLEN) && (sh' == PATTERN)
  - On hit, non-overlap mode: fc' forced to 0 and sh' kept. Matches never share bits.
- flush_i[k]=1 clears channel k's context at the edge and masks k from arbitration that cycle. Flush has priority over a simultaneous request: no ack, bit not consumed, requester keeps it pending.
- Ungranted channels' contexts are untouched. Channels are fully independent.
- Reset values: ack_o=0, det_valid_o=0, det_ch_o=0, det_o=0, ptr=0, all contexts cleared.
- Reset mid-operation: all state clears asynchronously. Partially received patterns are discarded. A pending req_i is re-arbitrated from ptr=0 after release.

## Timing
- Throughput: one bit per cycle in aggregate. With NCH channels continuously requesting, each channel gets 1/NCH.
- Latency: a bit accepted at edge T (ack_o[g]=1 in the cycle before T) produces det_valid_o=1, det_ch_o=g, det_o=hit in the cycle after T. These outputs are registered.
- det_valid_o=1 for exactly one cycle per accepted bit. det_o=0 when det_valid_o=0.
- Back-to-back grants to the same channel (sole requester) are legal. The write-back at edge T is visible to the grant at edge T+1; there is no bypass hazard.

## Configuration
- PATTERN_SCHED_OVERLAP_EN defined: fc is not cleared on hit, so overlapping matches are reported.
- PATTERN_SCHED_OVERLAP_EN undefined (default): non-overlap detection as specified above.

## Structure
- Package pattern_sched_pkg holds:
  - default PLEN and PATTERN constants
  - typedef struct packed ctx_t {sh, fc}
  - channel-index width function.
- Sub-module rr_arbiter (parameter N) takes req, mask and ptr and returns a one-hot grant and the grant index. The context bank and engine stay in pattern_sched.

## Test plan
- Ch0 alone streams 0,1,1,0,1: det_valid_o on each of 5 results; det_o=1, det_ch_o=0 only on the 5th.
- Ch0 streams 0,1,1,0,1,1,0,1: non-overlap gives one hit (bit 5). With PATTERN_SCHED_OVERLAP_EN, hits at bits 5 and 8.
- All 4 channels request continuously from reset: ack_o sequence 0001,0010,0100,1000,0001.
- Ch1 and ch2 interleave distinct streams; only ch2 contains 01101: det_o=1 with det_ch_o=2 exactly once; ch1 never hits.
- Ch0 sends 0,1,1, then flush_i[0] pulses together with req_i[0]: no ack that cycle. Then 0,1 gives no hit; full 0,1,1,0,1 afterwards hits.
- rst_ni dropped after 0,1,1,0 on ch3: outputs 0 immediately. After release, sending 1 alone gives no hit and ptr restarts at 0.

Source files
------------

// File: rtl/pattern_sched_pkg.sv
// Shared constants, context type and helpers for the pattern_sched channel scheduler.
package pattern_sched_pkg;

  localparam int PLEN_DEF = 5;
  localparam logic [PLEN_DEF-1:0] PATTERN_DEF = 5'b01101;

  // Context fields are sized for the largest supported pattern (16 bits).
  localparam int SH_MAX = 16;
  localparam int FC_W   = 5;

  typedef struct packed {
    logic [SH_MAX-1:0] sh;
    logic [FC_W-1:0]   fc;
  } ctx_t;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_sched_rr_arbiter.sv
// Round-robin arbiter: first unmasked requester at or after ptr wins, one-hot grant plus index.
module rr_arbiter
  import pattern_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = ch_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0]   pos;
  logic [W-1:0] sel;

  // Scan channels starting at ptr, wrapping modulo N; first eligible one is granted.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (W+1)'(i);
      if (pos >= (W+1)'(N)) begin
        pos = pos - (W+1)'(N);
      end else begin
        pos = pos;
      end
      sel = pos[W-1:0];
      if (!any && req[sel] && !mask[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/pattern_sched.sv
// Shared serial pattern detector time-multiplexed over NCH channels with a per-channel context bank.
// Define PATTERN_SCHED_OVERLAP_EN to keep the fill count on a hit so overlapping matches are reported.
module pattern_sched
  import pattern_sched_pkg::*;
#(
  parameter int                NCH     = 4,
  parameter int                PLEN    = PLEN_DEF,
  parameter logic [PLEN-1:0]   PATTERN = PATTERN_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH-1:0]           d_i,
  input  logic [NCH-1:0]           flush_i,
  output logic [NCH-1:0]           ack_o,
  output logic                     det_valid_o,
  output logic [$clog2(NCH)-1:0]   det_ch_o,
  output logic                     det_o
);

  localparam int CW = ch_width(NCH);
  localparam logic [SH_MAX-1:0] SH_MASK = SH_MAX'((33'd1 << PLEN) - 33'd1);

  ctx_t            ctx_r [NCH];
  ctx_t            cur_s;
  ctx_t            nxt_s;
  logic [SH_MAX-1:0] sh_new_s;
  logic [FC_W-1:0] fc_inc_s;
  logic            hit_s;
  logic [NCH-1:0]  gnt_s;
  logic [CW-1:0]   gidx_s;
  logic            any_s;
  logic [CW-1:0]   ptr_r;
  logic            det_valid_r;
  logic [CW-1:0]   det_ch_r;
  logic            det_r;

  rr_arbiter #(.N(NCH), .W(CW)) u_arb (
    .req  (req_i),
    .mask (flush_i),
    .ptr  (ptr_r),
    .gnt  (gnt_s),
    .idx  (gidx_s),
    .any  (any_s)
  );

  // Grants are suppressed while reset is held so nothing is acknowledged but not consumed.
  assign ack_o = gnt_s & {NCH{rst_ni}};

  // Advance the granted channel's context by its bit and evaluate the match.
  always_comb begin
    cur_s    = ctx_r[gidx_s];
    sh_new_s = ((cur_s.sh << 1) | SH_MAX'(d_i[gidx_s])) & SH_MASK;
    if (cur_s.fc >= FC_W'(PLEN)) begin
      fc_inc_s = FC_W'(PLEN);
    end else begin
      fc_inc_s = cur_s.fc + 5'd1;
    end
    hit_s    = (fc_inc_s == FC_W'(PLEN)) && (sh_new_s == SH_MAX'(PATTERN));
    nxt_s.sh = sh_new_s;
`ifdef PATTERN_SCHED_OVERLAP_EN
    nxt_s.fc = fc_inc_s;
`else
    if (hit_s) begin
      nxt_s.fc = '0;
    end else begin
      nxt_s.fc = fc_inc_s;
    end
`endif
  end

  // Context bank write-back, round-robin pointer and registered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NCH; k++) begin
        ctx_r[k] <= '0;
      end
      ptr_r       <= '0;
      det_valid_r <= 1'b0;
      det_ch_r    <= '0;
      det_r       <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (flush_i[k]) begin
          ctx_r[k] <= '0;
        end else if (gnt_s[k]) begin
          ctx_r[k] <= nxt_s;
        end else begin
          ctx_r[k] <= ctx_r[k];
        end
      end
      if (any_s) begin
        ptr_r <= (gidx_s == CW'(NCH-1)) ? '0 : gidx_s + CW'(1);
      end else begin
        ptr_r <= ptr_r;
      end
      det_valid_r <= any_s;
      det_ch_r    <= gidx_s;
      det_r       <= any_s & hit_s;
    end
  end

  assign det_valid_o = det_valid_r;
  assign det_ch_o    = det_ch_r;
  assign det_o       = det_r;

endmodule

// File: tb/tb_pattern_sched.sv
// Directed self-checking bench for pattern_sched (NCH=4, PATTERN=01101).
module tb_pattern_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] flush;
  logic [3:0] ack;
  logic       det_valid;
  logic [1:0] det_ch;
  logic       det;

  int errors = 0;
  int checks = 0;

  pattern_sched dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .d_i         (d),
    .flush_i     (flush),
    .ack_o       (ack),
    .det_valid_o (det_valid),
    .det_ch_o    (det_ch),
    .det_o       (det)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    flush = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Offer one bit on channel ch, wait (bounded) for its ack, and return the registered result.
  task automatic send_bit(input int ch, input logic b, output logic ok,
                          output logic v, output logic h, output logic [1:0] c);
    req[ch] = 1'b1;
    d[ch]   = b;
    ok      = 1'b0;
    v       = 1'b0;
    h       = 1'b0;
    c       = 2'd0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      ok = ack[ch];
    end
    if (ok) begin
      @(posedge clk);
      #1;
      v = det_valid;
      h = det;
      c = det_ch;
    end
    req[ch] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    d     = 4'b1111;
    flush = 4'b0000;
    #1;
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++;
    if (det_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", det_valid); end
    checks++;
    if (det !== 1'b0) begin errors++; $display("FAIL reset_det: got %b want 0", det); end
    checks++;
    if (det_ch !== 2'd0) begin errors++; $display("FAIL reset_ch: got %0d want 0", det_ch); end
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (ack !== 4'b0000 || det_valid !== 1'b0) begin
      errors++; $display("FAIL reset_held: ack %b valid %b want 0000 0", ack, det_valid);
    end
    do_reset();
  endtask

  task automatic test_single_pattern();
    logic [4:0] p;
    logic ok, v, h;
    logic [1:0] c;
    p = 5'b10110;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_bit(0, p[i], ok, v, h, c);
      checks++;
      if (!ok || v !== 1'b1 || c !== 2'd0 || h !== (i == 4)) begin
        errors++;
        $display("FAIL single_bit%0d: ok %b valid %b ch %0d det %b want 1 1 0 %b", i, ok, v, c, h, (i == 4));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (det_valid !== 1'b0 || det !== 1'b0) begin
      errors++; $display("FAIL single_idle: valid %b det %b want 0 0", det_valid, det);
    end
  endtask

  task automatic test_overlap_mode();
    logic [7:0] s;
    logic [7:0] hits;
    logic ok, v, h;
    logic [1:0] c;
    s = 8'b10110110;
`ifdef PATTERN_SCHED_OVERLAP_EN
    hits = 8'b10010000;
`else
    hits = 8'b00010000;
`endif
    flush = 4'b0001;
    @(posedge clk);
    #1;
    flush = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      send_bit(0, s[i], ok, v, h, c);
      checks++;
      if (!ok || v !== 1'b1 || c !== 2'd0 || h !== hits[i]) begin
        errors++;
        $display("FAIL overlap_bit%0d: ok %b valid %b ch %0d det %b want 1 1 0 %b", i, ok, v, c, h, hits[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ack [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    d   = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ack !== exp_ack[i]) begin
        errors++; $display("FAIL rr_ack%0d: got %b want %b", i, ack, exp_ack[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (det_valid !== 1'b1 || det_ch !== 2'(i % 4) || det !== 1'b0) begin
        errors++;
        $display("FAIL rr_res%0d: valid %b ch %0d det %b want 1 %0d 0", i, det_valid, det_ch, det, i % 4);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_interleave();
    logic [5:0] s1;
    logic [5:0] s2;
    logic [3:0] a;
    int i1 = 0;
    int i2 = 0;
    int hits1 = 0;
    int hits2 = 0;
    int cyc = 0;
    s1 = 6'b111111;
    s2 = 6'b101100;
    flush = 4'b0110;
    @(posedge clk);
    #1;
    flush = 4'b0000;
    while ((i1 < 6 || i2 < 6) && cyc < 40) begin
      req[1] = (i1 < 6);
      req[2] = (i2 < 6);
      if (i1 < 6) d[1] = s1[i1]; else d[1] = 1'b0;
      if (i2 < 6) d[2] = s2[i2]; else d[2] = 1'b0;
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      if (a[1]) i1++;
      if (a[2]) i2++;
      if (a != 4'b0000) begin
        checks++;
        if (det_valid !== 1'b1 || det_ch !== (a[2] ? 2'd2 : 2'd1)) begin
          errors++; $display("FAIL il_result: ack %b valid %b ch %0d", a, det_valid, det_ch);
        end
        if (det === 1'b1 && det_ch === 2'd1) hits1++;
        if (det === 1'b1 && det_ch === 2'd2) hits2++;
      end
      cyc++;
    end
    req = 4'b0000;
    checks++;
    if (i1 != 6 || i2 != 6) begin
      errors++; $display("FAIL il_timeout: consumed %0d/%0d want 6/6", i1, i2);
    end
    checks++;
    if (hits2 != 1) begin errors++; $display("FAIL il_ch2_hits: got %0d want 1", hits2); end
    checks++;
    if (hits1 != 0) begin errors++; $display("FAIL il_ch1_hits: got %0d want 0", hits1); end
  endtask

  task automatic test_flush();
    logic [2:0] pre;
    logic [4:0] post;
    logic ok, v, h;
    logic [1:0] c;
    pre  = 3'b110;
    post = 5'b10110;
    flush = 4'b0001;
    @(posedge clk);
    #1;
    flush = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      send_bit(0, pre[i], ok, v, h, c);
      checks++;
      if (!ok || v !== 1'b1 || h !== 1'b0) begin
        errors++; $display("FAIL flush_pre%0d: ok %b valid %b det %b want 1 1 0", i, ok, v, h);
      end
    end
    req[0]   = 1'b1;
    d[0]     = 1'b0;
    flush[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("FAIL flush_ack: got %b want 0000", ack); end
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    checks++;
    if (det_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", det_valid); end
    for (int i = 0; i < 5; i++) begin
      send_bit(0, post[i], ok, v, h, c);
      checks++;
      if (!ok || v !== 1'b1 || c !== 2'd0 || h !== (i == 4)) begin
        errors++;
        $display("FAIL flush_post%0d: ok %b valid %b ch %0d det %b want 1 1 0 %b", i, ok, v, c, h, (i == 4));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] p;
    logic ok, v, h;
    logic [1:0] c;
    p = 4'b0110;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_bit(3, p[i], ok, v, h, c);
    end
    send_bit(1, 1'b0, ok, v, h, c);
    checks++;
    if (!ok || det_ch !== 2'd1) begin errors++; $display("FAIL rm_setup: ok %b ch %0d want 1 1", ok, det_ch); end
    req[3] = 1'b1;
    d[3]   = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000 || det_valid !== 1'b0 || det !== 1'b0 || det_ch !== 2'd0) begin
      errors++;
      $display("FAIL rm_async: ack %b valid %b det %b ch %0d want 0000 0 0 0", ack, det_valid, det, det_ch);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    req[1] = 1'b1;
    d[1]   = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010) begin errors++; $display("FAIL rm_ptr0: got %b want 0010", ack); end
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("FAIL rm_ack3: got %b want 1000", ack); end
    @(posedge clk);
    #1;
    req[3] = 1'b0;
    checks++;
    if (det_valid !== 1'b1 || det_ch !== 2'd3 || det !== 1'b0) begin
      errors++; $display("FAIL rm_nohit: valid %b ch %0d det %b want 1 3 0", det_valid, det_ch, det);
    end
  endtask

  initial begin
    test_reset();
    test_single_pattern();
    test_overlap_mode();
    test_round_robin();
    test_interleave();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
